vga_timing: RTL
===============

# vga_timing

Video timing generator fed by the board clock/reset stage of the `fpga` top: it runs on the selected pixel clock and produces horizontal/vertical sync, the active-display flag, pixel coordinates and a one-cycle-early pixel-fetch request for the downstream pixel source (frame buffer FIFO). Sync widths and porches are parameters, so the same block drives both the 50 MHz and 27 MHz clock configurations. Frame generation is gated by an enable that is honoured only on frame boundaries.

## Interface
- HDISP, 800, active pixels per line
- HFP, 40, horizontal front porch (cycles)
- HPULSE, 48, HS pulse width (cycles)
- HBP, 40, horizontal back porch (cycles)
- VDISP, 480, active lines per frame
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, VS pulse width (lines)
- VBP, 29, vertical back porch (lines)
- Derived, not overridable: HTOTAL = HDISP+HFP+HPULSE+HBP (928), VTOTAL = VDISP+VFP+VPULSE+VBP (525); XW = $clog2(HTOTAL), YW = $clog2(VTOTAL)

- CLK  in  1  pixel clock; all state on rising edge
- NRST  in  1  asynchronous, active-low reset
- EN  in  1  request frame generation; sampled only at frame boundary
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_BLANK  out  1  1 = active display pixel, 0 = blanking
- PIX_X  out  XW  horizontal counter value
- PIX_Y  out  YW  vertical counter value
- RD_REQ  out  1  pixel fetch request, high exactly one cycle before each active pixel
- FRAME_START  out  1  one-cycle pulse at (0,0) of every generated frame
- BUSY  out  1  1 while a frame is in progress

## Operation
- Two states: IDLE, RUN.
- IDLE: counters held at (0,0); VGA_HS=VGA_VS=1, VGA_BLANK=0, RD_REQ=0, BUSY=0. If EN=1, next cycle enters RUN at (0,0) with FRAME_START=1.
- RUN: hcnt increments every cycle, 0..HTOTAL-1, wraps to 0 and increments vcnt; vcnt 0..VTOTAL-1.
- At last pixel of frame (HTOTAL-1, VTOTAL-1): EN=1 -> wrap to (0,0), stay RUN, FRAME_START=1; EN=0 -> enter IDLE. EN changes mid-frame are ignored; current frame always completes.
- Line layout: active [0, HDISP), front porch, sync [HDISP+HFP, HDISP+HFP+HPULSE), back porch. Vertical identical in lines.
- VGA_HS=0 when hcnt in sync window (every line, including vertical blanking lines). VGA_VS=0 when vcnt in vertical sync window, for whole lines.
- VGA_BLANK=1 iff hcnt<HDISP and vcnt<VDISP.
- RD_REQ=1 in the cycle preceding each cycle with VGA_BLANK=1: last cycle of previous line (hcnt=HTOTAL-1) for pixel 0 of active lines 1..VDISP-1, and for line 0 the last cycle of the previous frame, or the IDLE->RUN transition cycle. Exactly HDISP*VDISP requests per frame.
- PIX_X/PIX_Y equal hcnt/vcnt; meaningful as coordinates only when VGA_BLANK=1.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- VGA_HS, VGA_VS, VGA_BLANK, PIX_X, PIX_Y, FRAME_START, BUSY are mutually aligned: values in a cycle describe the same (hcnt,vcnt).
- EN=1 in IDLE -> FRAME_START and first active pixel one cycle after the sampling edge.
- Reset (any time, including mid-frame): asynchronously IDLE, counters 0, VGA_HS=1, VGA_VS=1, VGA_BLANK=0, RD_REQ=0, FRAME_START=0, BUSY=0, PIX_X=0, PIX_Y=0. After release, behaves as IDLE.
- Frame period 928*525 = 487 200 cycles with defaults; line period 928 cycles.

## Test plan
- Reset: NRST=0 for 10 cycles with EN=1 -> all outputs at reset values; release -> FRAME_START pulse at next edge, PIX_X=PIX_Y=0, VGA_BLANK=1.
- Horizontal: on line 0, VGA_BLANK=1 for exactly 800 cycles, VGA_HS low from hcnt 840 for 48 cycles, line length 928.
- Vertical: VGA_VS low for 3*928 cycles starting at line 493; consecutive FRAME_START pulses 487 200 cycles apart; 384 000 active pixels per frame.
- Prefetch: every RD_REQ followed next cycle by VGA_BLANK=1; count 384 000 per frame; none otherwise.
- Enable: drop EN at line 100 -> frame completes to (927,524), then IDLE with syncs high; raise EN -> new frame one cycle later.
- Mid-frame reset: assert NRST=0 at line 250 -> outputs reach reset values immediately; release with EN=1 -> clean frame from (0,0).

Source files
------------

// File: rtl/vga_timing.sv
// ============================================================================
// Module : vga_timing
// Parameterised VGA sync/blank/coordinate generator with frame-gated enable
// and one-cycle-early pixel fetch request.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_timing #(
    parameter  int HDISP  = 800,
    parameter  int HFP    = 40,
    parameter  int HPULSE = 48,
    parameter  int HBP    = 40,
    parameter  int VDISP  = 480,
    parameter  int VFP    = 13,
    parameter  int VPULSE = 3,
    parameter  int VBP    = 29,
    localparam int HTOTAL = HDISP + HFP + HPULSE + HBP,
    localparam int VTOTAL = VDISP + VFP + VPULSE + VBP,
    localparam int XW     = $clog2(HTOTAL),
    localparam int YW     = $clog2(VTOTAL)
) (
    input  logic          CLK,
    input  logic          NRST,
    input  logic          EN,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK,
    output logic [XW-1:0] PIX_X,
    output logic [YW-1:0] PIX_Y,
    output logic          RD_REQ,
    output logic          FRAME_START,
    output logic          BUSY
);

    localparam logic [XW-1:0] C_H_LAST   = XW'(HTOTAL - 1);
    localparam logic [YW-1:0] C_V_LAST   = YW'(VTOTAL - 1);
    localparam logic [XW:0]   C_H_DISP   = (XW+1)'(HDISP);
    localparam logic [XW:0]   C_HS_START = (XW+1)'(HDISP + HFP);
    localparam logic [XW:0]   C_HS_END   = (XW+1)'(HDISP + HFP + HPULSE);
    localparam logic [YW:0]   C_V_DISP   = (YW+1)'(VDISP);
    localparam logic [YW:0]   C_VS_START = (YW+1)'(VDISP + VFP);
    localparam logic [YW:0]   C_VS_END   = (YW+1)'(VDISP + VFP + VPULSE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   hcnt_q, hcnt_d;
    logic [YW-1:0]   vcnt_q, vcnt_d;
    logic            first_q, first_d;

    logic            hs_q, vs_q, blank_q, rd_req_q, fs_q, busy_q;
    logic [XW-1:0]   pix_x_q;
    logic [YW-1:0]   pix_y_q;

    logic            run_w;
    logic            hs_d, vs_d, blank_d, rd_req_d;

    // Counter/state stage: this is where EN is sampled.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        first_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (EN) begin
                    state_d = S_RUN;
                    first_d = 1'b1;
                end
            end
            S_RUN: begin
                if (hcnt_q == C_H_LAST) begin
                    hcnt_d = '0;
                    if (vcnt_q == C_V_LAST) begin
                        vcnt_d = '0;
                        if (EN) begin
                            first_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        vcnt_d = vcnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output stage lags the counters by one cycle, so the request can be
    // decoded from the counters' next value and lead the pixel by one cycle.
    always_comb begin
        run_w    = (state_q == S_RUN);
        hs_d     = ~(run_w && ({1'b0, hcnt_q} >= C_HS_START) && ({1'b0, hcnt_q} < C_HS_END));
        vs_d     = ~(run_w && ({1'b0, vcnt_q} >= C_VS_START) && ({1'b0, vcnt_q} < C_VS_END));
        blank_d  = run_w && ({1'b0, hcnt_q} < C_H_DISP) && ({1'b0, vcnt_q} < C_V_DISP);
        rd_req_d = (state_d == S_RUN) && ({1'b0, hcnt_d} < C_H_DISP) &&
                   ({1'b0, vcnt_d} < C_V_DISP);
    end

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q  <= S_IDLE;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            first_q  <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
            rd_req_q <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            first_q  <= first_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            blank_q  <= blank_d;
            rd_req_q <= rd_req_d;
            fs_q     <= first_q;
            busy_q   <= run_w;
            pix_x_q  <= hcnt_q;
            pix_y_q  <= vcnt_q;
        end
    end

    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK   = blank_q;
    assign PIX_X       = pix_x_q;
    assign PIX_Y       = pix_y_q;
    assign RD_REQ      = rd_req_q;
    assign FRAME_START = fs_q;
    assign BUSY        = busy_q;

endmodule

`default_nettype wire
